// File: rtl/bt656_video_out_encoder_if.sv
// Pixel stream handshake between a YCbCr 4:2:2 source and the BT.656 output encoder.
interface bt656_video_out_encoder_if;
    logic [15:0] stream_data;           // [15:8]=Y, [7:0]=C (Cb on even pixel, Cr on odd)
    logic        stream_startofpacket;  // first pixel of a field
    logic        stream_valid;
    logic        stream_ready;

    modport master (
        output stream_data,
        output stream_startofpacket,
        output stream_valid,
        input  stream_ready
    );

    modport slave (
        input  stream_data,
        input  stream_startofpacket,
        input  stream_valid,
        output stream_ready
    );
endinterface

// File: rtl/bt656_video_out_encoder.sv
// BT.656 output encoder: serialises a YCbCr 4:2:2 pixel stream into one byte per clock with
// EAV/SAV timing codes, blanking fill and F/V/H flags. Pixels are taken at Cb/Cr byte slots;
// the matching Y is held for the following slot.
module bt656_video_out_encoder #(
    parameter int unsigned ACTIVE_PIXELS = 720,
    parameter int unsigned HBLANK_BYTES  = 268,
    parameter int unsigned TOTAL_LINES   = 525,
    parameter int unsigned FIELD2_START  = 263,
    parameter int unsigned F1_ACT_START  = 19,
    parameter int unsigned F2_ACT_START  = 282,
    parameter int unsigned ACTIVE_LINES  = 240
) (
    input  logic                      clk,
    input  logic                      reset,
    bt656_video_out_encoder_if.slave  src,
    output logic [7:0]                td_data,
    output logic                      td_hs,
    output logic                      td_vs,
    output logic                      td_field,
    output logic                      underflow
);
    localparam int unsigned LineLen  = 8 + HBLANK_BYTES + 2 * ACTIVE_PIXELS;
    localparam int unsigned SavStart = 4 + HBLANK_BYTES;
    localparam int unsigned ActStart = 8 + HBLANK_BYTES;
    localparam int unsigned HW       = $clog2(LineLen);
    localparam int unsigned LW       = $clog2(TOTAL_LINES);

    typedef enum logic {StUnsync, StSync} sync_e;

    sync_e          sync_q, sync_d;
    logic [HW-1:0]  h_cnt_q, h_cnt_d;
    logic [LW-1:0]  line_q, line_d;
    logic [7:0]     td_data_q, td_data_d;
    logic           hs_q, vs_q, field_q, under_q, under_d;
    logic [7:0]     y_hold_q, y_hold_d;

    logic [31:0]    h_ext, line_ext;
    logic           line_f, line_v, act_c, field_first;
    logic           ready, accept;
    logic [7:0]     c_byte;

    function automatic logic [7:0] xy_code(input logic f, input logic v, input logic h);
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

    assign h_ext    = 32'(h_cnt_q);
    assign line_ext = 32'(line_q);
    assign line_f   = (line_ext >= FIELD2_START);
    assign line_v   = !(((line_ext >= F1_ACT_START) &&
                         (line_ext < F1_ACT_START + ACTIVE_LINES)) ||
                        ((line_ext >= F2_ACT_START) &&
                         (line_ext < F2_ACT_START + ACTIVE_LINES)));
    // ActStart is even, so even byte positions in the active region are C slots
    assign act_c       = !line_v && (h_ext >= ActStart) && !h_ext[0];
    assign field_first = act_c && (h_ext == ActStart) &&
                         ((line_ext == F1_ACT_START) || (line_ext == F2_ACT_START));

    assign src.stream_ready = ready && !reset;

    // Horizontal byte counter and line counter
    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        line_d  = line_q;
        if (h_ext == LineLen - 1) begin
            h_cnt_d = '0;
            line_d  = (line_ext == TOTAL_LINES - 1) ? '0 : line_q + 1'b1;
        end
    end

    // Sync tracking and pixel handshake: discard until a SOP lines up with a field start
    always_comb begin
        sync_d  = sync_q;
        ready   = 1'b0;
        accept  = 1'b0;
        under_d = 1'b0;
        if (sync_q == StUnsync) begin
            if (src.stream_valid && !src.stream_startofpacket) begin
                ready = 1'b1;
            end else if (src.stream_valid && field_first) begin
                ready  = 1'b1;
                accept = 1'b1;
                sync_d = StSync;
            end
        end else if (act_c) begin
            if (!src.stream_valid) begin
                under_d = 1'b1;
            end else if (src.stream_startofpacket != field_first) begin
                // SOP mid-field, or a field start without SOP: lose sync, emit black
                sync_d = StUnsync;
            end else begin
                ready  = 1'b1;
                accept = 1'b1;
            end
        end
    end

    // Output byte selection by position within the line
    always_comb begin
        y_hold_d = y_hold_q;
        c_byte   = accept ? src.stream_data[7:0] : 8'h80;
        if (act_c) begin
            y_hold_d = accept ? src.stream_data[15:8] : 8'h10;
        end
        if (h_ext == 0 || h_ext == SavStart) begin
            td_data_d = 8'hFF;
        end else if (h_ext < 3 || (h_ext > SavStart && h_ext < SavStart + 3)) begin
            td_data_d = 8'h00;
        end else if (h_ext == 3) begin
            td_data_d = xy_code(line_f, line_v, 1'b1);
        end else if (h_ext == SavStart + 3) begin
            td_data_d = xy_code(line_f, line_v, 1'b0);
        end else if (h_ext < SavStart) begin
            td_data_d = h_ext[0] ? 8'h10 : 8'h80;
        end else if (h_ext[0]) begin
            td_data_d = line_v ? 8'h10 : y_hold_q;
        end else begin
            td_data_d = c_byte;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= StUnsync;
            h_cnt_q   <= '0;
            line_q    <= '0;
            td_data_q <= 8'h10;
            hs_q      <= 1'b0;
            vs_q      <= 1'b1;
            field_q   <= 1'b0;
            under_q   <= 1'b0;
            y_hold_q  <= 8'h10;
        end else begin
            sync_q    <= sync_d;
            h_cnt_q   <= h_cnt_d;
            line_q    <= line_d;
            td_data_q <= td_data_d;
            hs_q      <= (h_ext < ActStart);
            vs_q      <= line_v;
            field_q   <= line_f;
            under_q   <= under_d;
            y_hold_q  <= y_hold_d;
        end
    end

    assign td_data   = td_data_q;
    assign td_hs     = hs_q;
    assign td_vs     = vs_q;
    assign td_field  = field_q;
    assign underflow = under_q;
endmodule

// File: tb/tb_bt656_video_out_encoder.sv
// Bench for bt656_video_out_encoder: directed vector table for the first two lines, scripted
// corner sequences, then randomised fields checked against a position-based reference model.
module tb_bt656_video_out_encoder;
    localparam int unsigned AP  = 4;
    localparam int unsigned HB  = 4;
    localparam int unsigned TL  = 10;
    localparam int unsigned F2S = 5;
    localparam int unsigned F1A = 1;
    localparam int unsigned F2A = 6;
    localparam int unsigned AL  = 3;
    localparam int unsigned L   = 8 + HB + 2 * AP;
    localparam int unsigned A0  = 8 + HB;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] td_data;
    logic       td_hs, td_vs, td_field, underflow;

    bt656_video_out_encoder_if vif ();

    bt656_video_out_encoder #(
        .ACTIVE_PIXELS (AP),
        .HBLANK_BYTES  (HB),
        .TOTAL_LINES   (TL),
        .FIELD2_START  (F2S),
        .F1_ACT_START  (F1A),
        .F2_ACT_START  (F2A),
        .ACTIVE_LINES  (AL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .src       (vif),
        .td_data   (td_data),
        .td_hs     (td_hs),
        .td_vs     (td_vs),
        .td_field  (td_field),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    typedef struct { bit sop; logic [7:0] y; logic [7:0] c; } pix_t;
    typedef struct {
        bit valid; bit sop; logic [15:0] data;
        bit ready; logic [7:0] td; bit hs; bit vs;
    } vec_t;

    pix_t        src_q[$];
    vec_t        vecs[40];
    logic [7:0]  tbl_bytes[40] = '{
        8'hFF, 8'h00, 8'h00, 8'hB6, 8'h80, 8'h10, 8'h80, 8'h10, 8'hFF, 8'h00,
        8'h00, 8'hAB, 8'h80, 8'h10, 8'h80, 8'h10, 8'h80, 8'h10, 8'h80, 8'h10,
        8'hFF, 8'h00, 8'h00, 8'h9D, 8'h80, 8'h10, 8'h80, 8'h10, 8'hFF, 8'h00,
        8'h00, 8'h80, 8'h60, 8'h50, 8'h61, 8'h51, 8'h62, 8'h52, 8'h63, 8'h53};
    logic [7:0]  l2_bytes[8] = '{8'h64, 8'h54, 8'h80, 8'h10, 8'h65, 8'h55, 8'h66, 8'h56};

    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned k;           // cycles since reset release
    bit          m_sync;      // model: locked to the source's field structure
    logic [7:0]  m_y;         // model: Y byte due at the next Y slot
    logic        s_ready, s_hs, s_vs, s_field, s_under;
    logic [7:0]  s_byte;
    bit          s_took;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s k=%0d got %h expected %h", name, k, got, exp);
        end
    endtask

    function automatic logic [7:0] xy(input bit f, input bit v, input bit h);
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

    // One byte clock: drive inputs, predict from line geometry, compare, advance.
    task automatic step(input bit valid, input bit sop, input logic [15:0] data);
        int unsigned p, n;
        bit          f, v, first, cpos, acc, e_ready, e_under;
        logic [7:0]  e_byte;
        p     = k % L;
        n     = (k / L) % TL;
        f     = (n >= F2S);
        v     = !((n >= F1A && n < F1A + AL) || (n >= F2A && n < F2A + AL));
        cpos  = !v && p >= A0 && ((p - A0) % 2 == 0);
        first = cpos && p == A0 && (n == F1A || n == F2A);
        acc = 0; e_ready = 0; e_under = 0;
        if (!m_sync) begin
            e_ready = valid && (!sop || first);
            if (valid && sop && first) begin acc = 1; m_sync = 1; end
        end else if (cpos) begin
            if (!valid) e_under = 1;
            else if (sop && !first) m_sync = 0;
            else if (!sop && first) m_sync = 0;
            else begin acc = 1; e_ready = 1; end
        end
        if (p < 4) e_byte = (p == 0) ? 8'hFF : (p == 3) ? xy(f, v, 1'b1) : 8'h00;
        else if (p < 4 + HB) e_byte = ((p - 4) % 2 == 0) ? 8'h80 : 8'h10;
        else if (p < A0) e_byte = (p == 4 + HB) ? 8'hFF : (p == A0 - 1) ? xy(f, v, 1'b0) : 8'h00;
        else if (v) e_byte = ((p - A0) % 2 == 0) ? 8'h80 : 8'h10;
        else if (cpos) begin
            e_byte = acc ? data[7:0] : 8'h80;
            m_y    = acc ? data[15:8] : 8'h10;
        end else e_byte = m_y;

        vif.stream_valid         = valid;
        vif.stream_startofpacket = sop;
        vif.stream_data          = data;
        #1;
        s_ready = vif.stream_ready;
        chk("ready", 8'(s_ready), 8'(e_ready));
        @(posedge clk);
        #1;
        s_byte = td_data; s_hs = td_hs; s_vs = td_vs; s_field = td_field; s_under = underflow;
        chk("td_data", s_byte, e_byte);
        chk("td_hs", 8'(s_hs), 8'(p < A0));
        chk("td_vs", 8'(s_vs), 8'(v));
        chk("td_field", 8'(s_field), 8'(f));
        chk("underflow", 8'(s_under), 8'(e_under));
        s_took = valid && e_ready;
        k++;
        @(negedge clk);
    endtask

    task automatic step_src(input bit en);
        bit   have;
        pix_t h;
        have = en && src_q.size() > 0;
        if (have) h = src_q[0];
        else h = '{sop: 1'b0, y: 8'($urandom), c: 8'($urandom)};
        step(have, h.sop, {h.y, h.c});
        if (s_took) void'(src_q.pop_front());
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_td_data"}, td_data, 8'h10);
        chk({tag, "_td_hs"}, 8'(td_hs), 8'h00);
        chk({tag, "_td_vs"}, 8'(td_vs), 8'h01);
        chk({tag, "_td_field"}, 8'(td_field), 8'h00);
        chk({tag, "_underflow"}, 8'(underflow), 8'h00);
        chk({tag, "_ready"}, 8'(vif.stream_ready), 8'h00);
    endtask

    task automatic model_reset();
        k = 0; m_sync = 0; m_y = 8'h10;
        src_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog k=%0d got timeout expected finish", k);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned kk;
        int          len;
        // Directed table for lines 0 and 1: SOP held from reset until line 1 first C slot
        for (int i = 0; i < 40; i++) begin
            vecs[i].valid = (i < 39);
            vecs[i].sop   = (i <= 32);
            vecs[i].data  = (i <= 32) ? 16'h5060 : (i <= 34) ? 16'h5161 :
                            (i <= 36) ? 16'h5262 : 16'h5363;
            vecs[i].ready = (i == 32 || i == 34 || i == 36 || i == 38);
            vecs[i].td    = tbl_bytes[i];
            vecs[i].hs    = (i % 20) < 12;
            vecs[i].vs    = (i < 20);
        end

        reset = 1'b1;
        vif.stream_valid = 1'b1; vif.stream_startofpacket = 1'b0; vif.stream_data = 16'h1234;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("por");
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].valid, vecs[i].sop, vecs[i].data);
            chk("tbl_ready", 8'(s_ready), 8'(vecs[i].ready));
            chk("tbl_byte", s_byte, vecs[i].td);
            chk("tbl_hs", 8'(s_hs), 8'(vecs[i].hs));
            chk("tbl_vs", 8'(s_vs), 8'(vecs[i].vs));
        end

        // Line 2 underflow, field-2 start without SOP, SOP held until the next field start
        for (int i = 0; i < 7; i++) src_q.push_back('{0, 8'h54 + 8'(i), 8'h64 + 8'(i)});
        for (int i = 0; i < 5; i++) src_q.push_back('{0, 8'h70 + 8'(i), 8'h71 + 8'(i)});
        src_q.push_back('{1, 8'hA0, 8'hB0});
        for (int i = 1; i < 4; i++) src_q.push_back('{0, 8'hA0 + 8'(i), 8'hB0 + 8'(i)});
        while (k < 240) begin
            kk = k;
            step_src(kk != 54);
            if (kk >= 52 && kk <= 59) chk("l2_byte", s_byte, l2_bytes[kk - 52]);
            if (kk >= 53 && kk <= 56) chk("l2_underflow", 8'(s_under), 8'(kk == 54));
            if (kk == 123) chk("f2_eav", s_byte, 8'hDA);
            if (kk == 131) chk("f2_sav", s_byte, 8'hC7);
            if (kk == 125) chk("f2_field", 8'(s_field), 8'h01);
            if (kk == 132) chk("nosop_black_c", s_byte, 8'h80);
            if (kk == 133) begin
                chk("nosop_black_y", s_byte, 8'h10);
                chk("discard_ready", 8'(s_ready), 8'h01);
            end
            if (kk == 183) chk("l9_eav", s_byte, 8'hF1);
            if (kk == 191) chk("l9_sav", s_byte, 8'hEC);
            if (kk == 200) chk("sop_held", 8'(s_ready), 8'h00);
            if (kk == 232) begin
                chk("sop_take_ready", 8'(s_ready), 8'h01);
                chk("sop_take_c", s_byte, 8'hB0);
            end
            if (kk == 233) chk("sop_take_y", s_byte, 8'hA0);
        end

        // Reset in the middle of a line
        repeat (7) step_src(1'b1);
        vif.stream_valid = 1'b1; vif.stream_startofpacket = 1'b0; vif.stream_data = 16'h1234;
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("midline");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        step_src(1'b0);
        chk("first_byte", s_byte, 8'hFF);

        // Random fields, occasionally one pixel short or long, with random valid gaps
        for (int i = 0; i < 600; i++) begin
            if (src_q.size() < 4) begin
                len = 12;
                case ($urandom_range(0, 9))
                    0: len = 11;
                    1: len = 13;
                    default: len = 12;
                endcase
                for (int j = 0; j < len; j++)
                    src_q.push_back('{j == 0, 8'($urandom), 8'($urandom)});
            end
            step_src($urandom_range(0, 9) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
